// File: rtl/fft_input_loader_if.sv
// Stream-in / frame-out bundle for the 32-point FFT input loader.
// The slave modport is the loader's view; master is the upstream/downstream view.
interface fft_input_loader_if #(
    parameter int p_inputBits = 9,
    parameter int p_points    = 32
);
    logic [p_inputBits-1:0]          i_sample;
    logic                            i_valid;
    logic                            o_ready;
    logic                            i_flush;
    logic [p_points*p_inputBits-1:0] o_frame;
    logic                            o_frameValid;
    logic                            i_frameAck;
    logic [4:0]                      o_fillCount;

    modport slave (
        input  i_sample, i_valid, i_flush, i_frameAck,
        output o_ready, o_frame, o_frameValid, o_fillCount
    );

    modport master (
        output i_sample, i_valid, i_flush, i_frameAck,
        input  o_ready, o_frame, o_frameValid, o_fillCount
    );
endinterface

// File: rtl/fft_input_loader.sv
// Serial-to-parallel FFT front end: samples land bit-reversed in a ping-pong
// pair of frame registers; the read bank is presented whole to stage 0.
module fft_input_loader #(
    parameter int p_inputBits = 9,
    parameter int p_points    = 32
) (
    input logic              CLK,
    input logic              RST,
    fft_input_loader_if.slave bus
);
    localparam int FRAME_W = p_points * p_inputBits;

    logic [FRAME_W-1:0] bank_q [2];
    logic [1:0]         full_q, full_d;
    logic               wr_bank_q, wr_bank_d;
    logic               rd_bank_q, rd_bank_d;
    logic [4:0]         wr_cnt_q, wr_cnt_d;
    logic               accept, complete, ack;
    logic [4:0]         wr_idx;

    function automatic logic [4:0] bitrev5(input logic [4:0] n);
        return {n[0], n[1], n[2], n[3], n[4]};
    endfunction

    // Flush wins over accept, so a sample presented with flush is dropped.
    assign accept   = bus.i_valid && !full_q[wr_bank_q] && !bus.i_flush;
    assign complete = accept && (wr_cnt_q == 5'd31);
    assign ack      = bus.i_frameAck && full_q[rd_bank_q];
    assign wr_idx   = bitrev5(wr_cnt_q);

    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_cnt_d  = wr_cnt_q;
        if (bus.i_flush) begin
            wr_cnt_d = 5'd0;
        end else if (accept) begin
            wr_cnt_d = wr_cnt_q + 5'd1;
        end
        // Completion and ack always target different banks, so both may apply.
        if (complete) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
        end
        if (ack) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bank_q[0] <= '0;
            bank_q[1] <= '0;
            full_q    <= 2'b00;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_cnt_q  <= 5'd0;
        end else begin
            if (accept) begin
                bank_q[wr_bank_q][wr_idx*p_inputBits +: p_inputBits] <= bus.i_sample;
            end
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_cnt_q  <= wr_cnt_d;
        end
    end

    assign bus.o_ready      = !full_q[wr_bank_q];
    assign bus.o_frameValid = full_q[rd_bank_q];
    assign bus.o_frame      = bank_q[rd_bank_q];
    assign bus.o_fillCount  = wr_cnt_q;
endmodule

// File: tb/tb_fft_input_loader.sv
// Scoreboard bench for fft_input_loader: loaded frames are queued as expected
// results and a monitor checks each frame as downstream acknowledges it.
module tb_fft_input_loader;
    localparam int W  = 9;
    localparam int FW = 32 * W;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    logic [FW-1:0] expq[$];
    logic [FW-1:0] exp_a, exp_b, exp_c, exp_d, exp_e;

    fft_input_loader_if #(.p_inputBits(W), .p_points(32)) dut_if ();

    fft_input_loader #(.p_inputBits(W), .p_points(32)) u_dut (
        .CLK (clk),
        .RST (rst),
        .bus (dut_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] brev(input logic [4:0] n);
        return {n[0], n[1], n[2], n[3], n[4]};
    endfunction

    // Frame whose sample n = base+n, placed at FFT index bitrev(n).
    function automatic logic [FW-1:0] build_frame(input int base);
        logic [FW-1:0] f;
        logic [4:0]    k;
        f = '0;
        for (int n = 0; n < 32; n++) begin
            k = brev(5'(n));
            f[k*W +: W] = 9'(base + n);
        end
        return f;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic chk_frame(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    // Monitor: a frame handshake at the coming edge pops the oldest expected frame.
    always @(negedge clk) begin
        if (!rst && dut_if.o_frameValid && dut_if.i_frameAck) begin
            if (expq.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected_frame: got %h expected none", dut_if.o_frame);
            end else begin
                chk_frame("sb_frame", dut_if.o_frame, expq.pop_front());
            end
        end
    end

    task automatic send(input logic [W-1:0] v);
        dut_if.i_valid  = 1'b1;
        dut_if.i_sample = v;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dut_if.i_valid  = 1'b0;
        dut_if.i_sample = '0;
    endtask

    task automatic load_frame(input int base);
        for (int n = 0; n < 32; n++) send(9'(base + n));
        idle();
        expq.push_back(build_frame(base));
    endtask

    task automatic pulse_ack();
        dut_if.i_frameAck = 1'b1;
        @(posedge clk);
        #1;
        dut_if.i_frameAck = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        expq.delete();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        dut_if.i_sample   = '0;
        dut_if.i_valid    = 1'b0;
        dut_if.i_flush    = 1'b0;
        dut_if.i_frameAck = 1'b0;
        #3;
        chk("rst_frameValid", 32'(dut_if.o_frameValid), 32'd0);
        chk("rst_ready", 32'(dut_if.o_ready), 32'd1);
        chk("rst_fillCount", 32'(dut_if.o_fillCount), 32'd0);
        chk_frame("rst_frame", dut_if.o_frame, '0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Ack with nothing valid must be ignored.
        pulse_ack();
        chk("ack_ignored_valid", 32'(dut_if.o_frameValid), 32'd0);

        // Test 1: x[n] = n+1
        for (int n = 0; n < 31; n++) send(9'(n + 1));
        chk("t1_valid_before", 32'(dut_if.o_frameValid), 32'd0);
        chk("t1_fill31", 32'(dut_if.o_fillCount), 32'd31);
        send(9'd32);
        idle();
        expq.push_back(build_frame(1));
        chk("t1_valid_after", 32'(dut_if.o_frameValid), 32'd1);
        chk("t1_fill_wrap", 32'(dut_if.o_fillCount), 32'd0);
        chk("t1_k0", 32'(dut_if.o_frame[0*W +: W]), 32'd1);
        chk("t1_k16", 32'(dut_if.o_frame[16*W +: W]), 32'd2);
        chk("t1_k8", 32'(dut_if.o_frame[8*W +: W]), 32'd3);
        chk("t1_k31", 32'(dut_if.o_frame[31*W +: W]), 32'd32);
        pulse_ack();
        chk("t1_valid_after_ack", 32'(dut_if.o_frameValid), 32'd0);

        // Test 2/3: fill both banks, overflow ignored, then ack once
        do_reset();
        exp_a = build_frame(10);
        exp_b = build_frame(300);
        load_frame(10);
        chk("t2_ready_mid", 32'(dut_if.o_ready), 32'd1);
        load_frame(300);
        chk("t2_ready_full", 32'(dut_if.o_ready), 32'd0);
        for (int i = 0; i < 3; i++) send(9'h155);
        idle();
        chk("t2_ready_still0", 32'(dut_if.o_ready), 32'd0);
        chk("t2_fill_ignored", 32'(dut_if.o_fillCount), 32'd0);
        chk_frame("t2_frame0_kept", dut_if.o_frame, exp_a);
        pulse_ack();
        chk_frame("t3_frame1_shown", dut_if.o_frame, exp_b);
        chk("t3_ready", 32'(dut_if.o_ready), 32'd1);
        chk("t3_valid", 32'(dut_if.o_frameValid), 32'd1);
        pulse_ack();

        // Test 4: partial load, flush carrying 0x1FF, then full frame
        for (int n = 0; n < 10; n++) send(9'(50 + n));
        idle();
        chk("t4_fill10", 32'(dut_if.o_fillCount), 32'd10);
        dut_if.i_flush = 1'b1;
        send(9'h1FF);
        dut_if.i_flush = 1'b0;
        idle();
        chk("t4_fill_flushed", 32'(dut_if.o_fillCount), 32'd0);
        chk("t4_valid_none", 32'(dut_if.o_frameValid), 32'd0);
        load_frame(100);
        chk("t4_k16", 32'(dut_if.o_frame[16*W +: W]), 32'd101);
        pulse_ack();

        // Test 5: last sample of frame D coincides with ack of frame C
        exp_c = build_frame(200);
        exp_d = build_frame(400);
        load_frame(200);
        for (int n = 0; n < 31; n++) send(9'(400 + n));
        dut_if.i_frameAck = 1'b1;
        send(9'(431));
        dut_if.i_frameAck = 1'b0;
        idle();
        expq.push_back(exp_d);
        chk("t5_valid", 32'(dut_if.o_frameValid), 32'd1);
        chk_frame("t5_frameD", dut_if.o_frame, exp_d);
        chk("t5_ready", 32'(dut_if.o_ready), 32'd1);
        chk("t5_fill", 32'(dut_if.o_fillCount), 32'd0);
        pulse_ack();

        // Test 6: asynchronous reset mid-frame with one bank full
        exp_e = build_frame(20);
        load_frame(20);
        for (int n = 0; n < 20; n++) send(9'(60 + n));
        idle();
        chk("t6_fill20", 32'(dut_if.o_fillCount), 32'd20);
        chk_frame("t6_frameE", dut_if.o_frame, exp_e);
        #2;
        rst = 1'b1;
        expq.delete();
        #1;
        chk("t6_valid", 32'(dut_if.o_frameValid), 32'd0);
        chk("t6_ready", 32'(dut_if.o_ready), 32'd1);
        chk("t6_fill", 32'(dut_if.o_fillCount), 32'd0);
        chk_frame("t6_frame", dut_if.o_frame, '0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        chk("sb_drained", 32'(expq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fft_input_loader.md
Name: fft_input_loader

Overview:
Serial-to-parallel front end of the 32-point FFT pipeline. It accepts time-domain samples one per cycle over a valid/ready stream and writes them into a ping-pong register bank in bit-reversed order. It presents each completed 32-sample frame as a parallel word to the stage-0 butterfly stage, which feeds Stage1.
Double buffering lets the next frame load while the downstream stages consume the current one.

Parameters:
p_inputBits, 9, width of one sample; equals the stage-0 input width.
p_points, 32, points per frame; fixed at 32, so the index width is 5.

Ports:
CLK  input  1  clock, rising edge.
RST  input  1  asynchronous, active-high reset.
i_sample  input  p_inputBits  serial time-domain sample x[n].
i_valid  input  1  i_sample is valid this cycle.
o_ready  output  1  loader can accept a sample this cycle.
i_flush  input  1  synchronous; discards the partially loaded frame.
o_frame  output  32*p_inputBits  parallel frame; FFT input index k occupies bits [k*p_inputBits +: p_inputBits].
o_frameValid  output  1  o_frame holds a complete frame.
i_frameAck  input  1  downstream has taken the frame.
o_fillCount  output  5  samples loaded into the current write bank.

Behaviour:
- Reset (async, RST=1):
  - both banks cleared to 0; full[1:0]=0; wrBank=0; rdBank=0; wrCnt=0.
  - outputs: o_frame=0, o_frameValid=0, o_ready=1, o_fillCount=0.
- Accept condition: i_valid && o_ready at a rising edge.
  - Write i_sample into bank[wrBank][bitrev5(wrCnt)], then wrCnt+1.
  - Examples: n=0->k0, n=1->k16, n=2->k8, n=31->k31.
- o_ready = !full[wrBank]. Combinational from registers only, with no dependence on i_valid.
- Frame completion, on the edge accepting the sample with wrCnt==31:
  - set full[wrBank]=1;
  - toggle wrBank;
  - wrCnt wraps to 0.
- o_frameValid = full[rdBank]; o_frame = bank[rdBank]. Both are register-driven.
  - Latency: o_frameValid rises in the cycle after the 32nd sample is accepted, when rdBank points to that bank.
- Output handshake: i_frameAck && o_frameValid at an edge clears full[rdBank] and toggles rdBank.
  - i_frameAck while o_frameValid=0 is ignored.
  - o_frame is stable while o_frameValid=1 and no ack has been seen.
- Both banks full: o_ready=0 and no write occurs; i_sample is ignored. An ack frees a bank, and o_ready rises the next cycle.
- Simultaneous completion and ack in the same cycle: both take effect. The banks always differ in this case, because completing needs !full[wrBank] and acking needs full[rdBank].
- i_flush=1:
  - wrCnt=0; partial data is not cleared but is overwritten by the next frame.
  - full flags and rdBank are untouched, so a completed frame stays valid.
  - A sample presented with i_flush is discarded and not counted; flush has priority over accept.
- o_fillCount = wrCnt.
- Reset mid-frame or mid-handshake returns everything to the reset state immediately.

Test Plan:
1. Reset, then stream x[n]=n+1 for n=0..31 with i_valid=1 every cycle:
   - o_frameValid rises one cycle after the 32nd accept;
   - o_frame k0=1, k16=2, k8=3, k31=32;
   - o_fillCount=0 after the wrap.
2. No ack, stream 64 samples continuously:
   - the first 32 fill bank 0 and the next 32 fill bank 1;
   - o_ready drops after the 64th accept;
   - samples 65 and onward are ignored and frame 0 data is unchanged.
3. From the full-full state, pulse i_frameAck once:
   - o_frame switches to frame 1 data next cycle;
   - o_ready=1 next cycle;
   - o_frameValid stays 1.
4. Load 10 samples, assert i_flush with i_valid=1 and value 0x1FF, then load 32 samples x=100+n:
   - o_fillCount goes 10->0;
   - the frame contains only 100..131 in bit-reversed order;
   - 0x1FF does not appear.
5. Accept the 32nd sample of frame 1 in the same cycle as the ack of frame 0:
   - o_frameValid stays 1;
   - o_frame shows frame 1 next cycle;
   - wrBank is back to 0 and o_ready=1.
6. Assert RST asynchronously mid-frame (wrCnt=20, one bank full):
   - o_frameValid=0, o_frame=0, o_ready=1, o_fillCount=0 before the next clock edge.
